param_cascade_counter: RTL
==========================

# param_cascade_counter

Parametrised cascaded digit counter: DIGITS stages of DIGIT_W bits, each counting modulo MODULUS, chained by per-stage ripple-carry outputs. Generalises the fixed two-nibble 8-bit counter to arbitrary digit count and radix. Adds up/down counting, parallel load, a one-shot stop-at-terminal mode and a registered wrap pulse. Used wherever the design needs binary or BCD event counters with per-digit carries exposed.

## Interface
- DIGITS, 2, number of cascaded stages (>=1)
- DIGIT_W, 4, bits per stage
- MODULUS, 16, per-stage count modulus (2..2^DIGIT_W; 10 gives BCD)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  count enable for stage 0
- up_dn  in  1  1 = count up, 0 = count down
- load  in  1  synchronous parallel load
- load_val  in  DIGITS*DIGIT_W  load value, stage i at bits [i*DIGIT_W +: DIGIT_W]
- oneshot  in  1  1 = stop at terminal count instead of wrapping
- count  out  DIGITS*DIGIT_W  current count, same packing as load_val
- rco  out  DIGITS  per-stage ripple carry/borrow out
- tc  out  1  whole-counter terminal count, equals rco[DIGITS-1]
- wrap  out  1  one-cycle registered pulse after the counter wraps
- done  out  1  sticky flag: one-shot mode reached terminal count

## Operation
- Stage terminal value: MODULUS-1 when up_dn=1, 0 when up_dn=0.
- rco[i] (combinational) = enable & (stage i at terminal) & (i==0 | rco[i-1]).
- Stage i advances when enable & (i==0 | rco[i-1]) & !halt.
  - Up: MODULUS-1 -> 0, else +1. Down: 0 -> MODULUS-1, else -1.
- halt = oneshot & tc. In one-shot mode, the counter holds at terminal and does not wrap.
- Priority, highest first: reset, load, count.
- load=1: each stage is loaded from its load_val field. A field >= MODULUS is clamped to MODULUS-1. enable is ignored that cycle. done is cleared and wrap is 0 next cycle.
- wrap: set for exactly one cycle after an edge where tc=1, oneshot=0 and load=0, i.e. the whole counter rolled over. Otherwise 0.
- done: set on the edge where tc=1, oneshot=1 and load=0. Held until load or reset.
- up_dn may change on any cycle. The next edge uses the new direction, and rco/tc reflect it combinationally.
- enable=0: count, done and wrap hold, except that wrap returns to 0. rco and tc are 0.

## Timing
- Reset (reset=0, asynchronous): count=0, wrap=0, done=0 immediately. rco=0 and tc=0 while reset is asserted.
- Reset deassertion is synchronised by the user. The first count happens on the first rising edge with reset=1 and enable=1.
- Count latency is 1 cycle: a change in count is visible after the enabling edge.
- rco/tc are combinational from count, enable and up_dn in the same cycle, with no added latency. The carry chain is DIGITS levels deep.
- wrap and done update on the edge after the condition; wrap is high for 1 clk period.
- Reset asserted mid-count clears all state within the same cycle. There is no partial-stage update.
- Full-scale period in free-run mode is MODULUS^DIGITS enabled cycles between wrap pulses.

## Test plan
- Reset/free-run binary (DIGITS=2, MODULUS=16), up, enable=1 after reset release:
  - count goes 0x00 -> 0x0F -> 0x10.
  - rco[0]=1 at each x0F.
  - At 0xFF: tc=1, next count 0x00, wrap=1 for one cycle, every 256 cycles.
- BCD down (MODULUS=10), load_val=0x20 then up_dn=0:
  - count goes 0x20 -> 0x19 -> ... -> 0x00, with rco[0]=1 at x0 values.
  - tc=1 at 0x00, next 0x99, wrap pulse.
- One-shot up, BCD, load 0x97, oneshot=1:
  - count goes 0x98 -> 0x99 and then holds.
  - done=1 from the edge after 0x99 is reached; wrap stays 0.
  - A subsequent load 0x00 clears done.
- Load priority and clamp, BCD: load=1 with enable=1 and load_val=0xCF gives count=0x99. Count does not advance on that edge.
- Enable gating and direction flip:
  - enable=0 at count 0x3F (binary): count, rco and tc hold/0 for 5 cycles.
  - Re-enable with up_dn toggled each cycle: count alternates 0x3F/0x40.
- Async reset mid-operation: assert reset=0 between edges at count 0x7A with done=1. count=0, done=0 and wrap=0 before the next edge.

Source files
------------

// File: rtl/param_cascade_counter_if.sv
// Control and status bundle for param_cascade_counter.
// The master drives the controls and the slave (the counter) drives the status outputs.
interface param_cascade_counter_if #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned DIGIT_W = 4
);
  logic                        enable;
  logic                        up_dn;
  logic                        load;
  logic [DIGITS*DIGIT_W-1:0]   load_val;
  logic                        oneshot;
  logic [DIGITS*DIGIT_W-1:0]   count;
  logic [DIGITS-1:0]           rco;
  logic                        tc;
  logic                        wrap;
  logic                        done;

  modport master (
    output enable, up_dn, load, load_val, oneshot,
    input  count, rco, tc, wrap, done
  );

  modport slave (
    input  enable, up_dn, load, load_val, oneshot,
    output count, rco, tc, wrap, done
  );
endinterface

// File: rtl/param_cascade_counter.sv
// Cascaded modulo-MODULUS digit counter with exposed per-stage carries.
// Supports up/down counting, parallel load with clamp, one-shot stop, and a wrap pulse.
module param_cascade_counter #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  param_cascade_counter_if.slave bus
);

  localparam int unsigned        CNT_W = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] TOP_V = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] digit_q [DIGITS];
  logic [DIGIT_W-1:0] digit_d [DIGITS];
  logic [DIGITS-1:0]  rco_c;
  logic [DIGITS-1:0]  adv_c;
  logic               carry_c;
  logic               term_c;
  logic               tc_c;
  logic               halt_c;
  logic [DIGIT_W-1:0] fld_c;
  logic [CNT_W-1:0]   count_c;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;

  function automatic logic [DIGIT_W-1:0] step_digit(input logic [DIGIT_W-1:0] d,
                                                    input logic               up);
    if (up) return (d == TOP_V) ? '0 : d + DIGIT_W'(1);
    return (d == '0) ? TOP_V : d - DIGIT_W'(1);
  endfunction

  // Ripple chain: carry into stage i is enable AND every lower stage at terminal.
  // Reset gates the chain so rco/tc read 0 while the counter is held in reset.
  always_comb begin
    rco_c   = '0;
    adv_c   = '0;
    term_c  = 1'b0;
    carry_c = bus.enable & reset;
    for (int i = 0; i < DIGITS; i++) begin
      term_c   = bus.up_dn ? (digit_q[i] == TOP_V) : (digit_q[i] == '0);
      adv_c[i] = carry_c;
      carry_c  = carry_c & term_c;
      rco_c[i] = carry_c;
    end
  end

  assign tc_c   = rco_c[DIGITS-1];
  assign halt_c = bus.oneshot & tc_c;

  // Next state: load beats counting; a held one-shot freezes every stage.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) digit_d[i] = digit_q[i];
    fld_c  = '0;
    wrap_d = 1'b0;
    done_d = done_q;
    if (bus.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        fld_c      = bus.load_val[i*DIGIT_W +: DIGIT_W];
        digit_d[i] = (32'(fld_c) >= MODULUS) ? TOP_V : fld_c;
      end
      done_d = 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (adv_c[i] && !halt_c) digit_d[i] = step_digit(digit_q[i], bus.up_dn);
      end
      wrap_d = tc_c & ~bus.oneshot;
      if (halt_c) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= digit_d[i];
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    count_c = '0;
    for (int i = 0; i < DIGITS; i++) count_c[i*DIGIT_W +: DIGIT_W] = digit_q[i];
  end

  assign bus.count = count_c;
  assign bus.rco   = rco_c;
  assign bus.tc    = tc_c;
  assign bus.wrap  = wrap_q;
  assign bus.done  = done_q;

endmodule
